// File: rtl/slot_payout_if.sv
// Slot payout bus: groups the spin/reel handshake and the result/credit
// outputs of slot_payout into one bundle.
//   master : drives spin/reel requests, observes results (testbench side)
//   slave  : consumes spin/reel requests, produces results (slot_payout)
// Signals:
//   i_spin_start   one-cycle spin request
//   i_reels_valid  one-cycle pulse, reels stopped and i_reel0..2 stable
//   i_reel0..2     stopped reel digits (0..9 valid)
//   o_start_ok     one-cycle pulse, spin accepted
//   o_start_deny   one-cycle pulse, spin refused (insufficient credit)
//   o_result_valid one-cycle pulse, payout computed
//   o_win          level, last evaluated spin paid more than 0
//   o_payout       binary payout of the last evaluated spin
//   o_credit_bcd   credit as three BCD digits, hundreds in [11:8]
//   o_busy         1 whenever the controller is not idle
interface slot_payout_if;
  logic        i_spin_start;
  logic        i_reels_valid;
  logic [3:0]  i_reel0;
  logic [3:0]  i_reel1;
  logic [3:0]  i_reel2;
  logic        o_start_ok;
  logic        o_start_deny;
  logic        o_result_valid;
  logic        o_win;
  logic [5:0]  o_payout;
  logic [11:0] o_credit_bcd;
  logic        o_busy;

  modport master (
    output i_spin_start, i_reels_valid, i_reel0, i_reel1, i_reel2,
    input  o_start_ok, o_start_deny, o_result_valid, o_win, o_payout,
           o_credit_bcd, o_busy
  );

  modport slave (
    input  i_spin_start, i_reels_valid, i_reel0, i_reel1, i_reel2,
    output o_start_ok, o_start_deny, o_result_valid, o_win, o_payout,
           o_credit_bcd, o_busy
  );
endinterface

// File: rtl/slot_payout.sv
// Slot machine payout controller. Deducts the bet on a spin request, latches
// the stopped reels, evaluates the payout table and pays the winnings into a
// three-digit BCD credit register one unit per cycle, saturating at 999.
// Ports:
//   i_clock  clock, all state updates on its rising edge
//   i_reset  synchronous active-high reset
//   bus      slot_payout_if.slave (spin/reel requests in, results out)
//
// state | meaning
// IDLE  | waiting for a spin request; reel strobes ignored
// SPIN  | bet taken, waiting for the reels to stop
// EVAL  | one cycle, reels latched, payout computed on its edge
// PAY   | moving payout into credit, one unit per cycle
module slot_payout #(
  parameter int START_CREDIT = 10,
  parameter int BET          = 1
) (
  input logic          i_clock,
  input logic          i_reset,
  slot_payout_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SPIN, EVAL, PAY} state_t;

  localparam logic [3:0] BET_D   = 4'(BET);
  localparam logic [3:0] START_H = 4'(START_CREDIT / 100);
  localparam logic [3:0] START_T = 4'((START_CREDIT / 10) % 10);
  localparam logic [3:0] START_O = 4'(START_CREDIT % 10);

  state_t      state, state_nx;
  logic [3:0]  cred_h, cred_t, cred_o;
  logic [3:0]  cred_h_nx, cred_t_nx, cred_o_nx;
  logic [3:0]  reel0_q, reel1_q, reel2_q;
  logic [3:0]  reel0_nx, reel1_nx, reel2_nx;
  logic [5:0]  payout_q, payout_nx, remain_q, remain_nx;
  logic        win_q, win_nx;
  logic        ok_q, ok_nx, deny_q, deny_nx, rv_q, rv_nx;
  logic [5:0]  eval_pay;
  logic        can_bet, at_max;

  always_comb begin
    eval_pay = 6'd0;
    if (reel0_q > 4'd9 || reel1_q > 4'd9 || reel2_q > 4'd9) begin
      eval_pay = 6'd0;
    end else if (reel0_q == reel1_q && reel1_q == reel2_q) begin
      eval_pay = (reel0_q == 4'd7) ? 6'd50 : 6'd10;
    end else if (reel0_q == reel1_q || reel1_q == reel2_q || reel0_q == reel2_q) begin
      eval_pay = 6'd2;
    end
  end

  assign can_bet = (cred_h != 4'd0) || (cred_t != 4'd0) || (cred_o >= BET_D);
  assign at_max  = (cred_h == 4'd9) && (cred_t == 4'd9) && (cred_o == 4'd9);

  always_comb begin
    state_nx  = state;
    cred_h_nx = cred_h;
    cred_t_nx = cred_t;
    cred_o_nx = cred_o;
    reel0_nx  = reel0_q;
    reel1_nx  = reel1_q;
    reel2_nx  = reel2_q;
    payout_nx = payout_q;
    remain_nx = remain_q;
    win_nx    = win_q;
    ok_nx     = 1'b0;
    deny_nx   = 1'b0;
    rv_nx     = 1'b0;
    case (state)
      IDLE: begin
        // A request arriving while a refusal is still being signalled is
        // dropped: credit cannot change in IDLE, so it would be refused
        // again, and a back-to-back deny pulse would stretch past one cycle.
        if (bus.i_spin_start && !deny_q) begin
          if (can_bet) begin
            // BET is a single digit, so a borrow only ever starts at ones.
            if (cred_o >= BET_D) begin
              cred_o_nx = cred_o - BET_D;
            end else begin
              cred_o_nx = cred_o + 4'd10 - BET_D;
              if (cred_t != 4'd0) begin
                cred_t_nx = cred_t - 4'd1;
              end else begin
                cred_t_nx = 4'd9;
                cred_h_nx = cred_h - 4'd1;
              end
            end
            ok_nx    = 1'b1;
            state_nx = SPIN;
          end else begin
            deny_nx = 1'b1;
          end
        end
      end
      SPIN: begin
        if (bus.i_reels_valid) begin
          reel0_nx = bus.i_reel0;
          reel1_nx = bus.i_reel1;
          reel2_nx = bus.i_reel2;
          state_nx = EVAL;
        end
      end
      EVAL: begin
        payout_nx = eval_pay;
        remain_nx = eval_pay;
        win_nx    = (eval_pay != 6'd0);
        rv_nx     = 1'b1;
        state_nx  = (eval_pay != 6'd0) ? PAY : IDLE;
      end
      PAY: begin
        if (at_max) begin
          remain_nx = 6'd0;
          state_nx  = IDLE;
        end else begin
          if (cred_o != 4'd9) begin
            cred_o_nx = cred_o + 4'd1;
          end else begin
            cred_o_nx = 4'd0;
            if (cred_t != 4'd9) begin
              cred_t_nx = cred_t + 4'd1;
            end else begin
              cred_t_nx = 4'd0;
              cred_h_nx = cred_h + 4'd1;
            end
          end
          remain_nx = remain_q - 6'd1;
          if (remain_q == 6'd1) begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state    <= IDLE;
      cred_h   <= START_H;
      cred_t   <= START_T;
      cred_o   <= START_O;
      reel0_q  <= 4'd0;
      reel1_q  <= 4'd0;
      reel2_q  <= 4'd0;
      payout_q <= 6'd0;
      remain_q <= 6'd0;
      win_q    <= 1'b0;
      ok_q     <= 1'b0;
      deny_q   <= 1'b0;
      rv_q     <= 1'b0;
    end else begin
      state    <= state_nx;
      cred_h   <= cred_h_nx;
      cred_t   <= cred_t_nx;
      cred_o   <= cred_o_nx;
      reel0_q  <= reel0_nx;
      reel1_q  <= reel1_nx;
      reel2_q  <= reel2_nx;
      payout_q <= payout_nx;
      remain_q <= remain_nx;
      win_q    <= win_nx;
      ok_q     <= ok_nx;
      deny_q   <= deny_nx;
      rv_q     <= rv_nx;
    end
  end

  assign bus.o_start_ok     = ok_q;
  assign bus.o_start_deny   = deny_q;
  assign bus.o_result_valid = rv_q;
  assign bus.o_win          = win_q;
  assign bus.o_payout       = payout_q;
  assign bus.o_credit_bcd   = {cred_h, cred_t, cred_o};
  assign bus.o_busy         = (state != IDLE);

endmodule

// File: doc/slot_payout.md
SLOT_PAYOUT -- requirements
Module: slot_payout

Interface
REQ-001 The module SHALL have parameter START_CREDIT, default 10, which is the credit loaded at reset (0..999, decimal).
REQ-002 The module SHALL have parameter BET, default 1, which is the credit cost of one spin (1..9).
REQ-003 The module SHALL have port i_clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port i_reset, input, 1 bit; reset is synchronous and active-high.
REQ-005 The module SHALL have port i_spin_start, input, 1 bit, a one-cycle request to start a spin (bet deduction).
REQ-006 The module SHALL have port i_reels_valid, input, 1 bit, a one-cycle pulse indicating that all three reels have stopped and i_reel0..2 are stable.
REQ-007 The module SHALL have ports i_reel0, i_reel1 and i_reel2, each input, 4 bits, the stopped reel digits (valid range 0..9).
REQ-008 The module SHALL have port o_start_ok, output, 1 bit, a one-cycle pulse when a spin is accepted.
REQ-009 The module SHALL have port o_start_deny, output, 1 bit, a one-cycle pulse when a spin is refused for insufficient credit.
REQ-010 The module SHALL have port o_result_valid, output, 1 bit, a one-cycle pulse when the payout for the latched reels has been computed.
REQ-011 The module SHALL have port o_win, output, 1 bit, a level that is 1 when the last evaluated spin paid more than 0.
REQ-012 The module SHALL have port o_payout, output, 6 bits, the binary payout of the last evaluated spin.
REQ-013 The module SHALL have port o_credit_bcd, output, 12 bits, the credit as three BCD digits, hundreds in [11:8].
REQ-014 The module SHALL have port o_busy, output, 1 bit, which is 1 in every state except IDLE.

Function
REQ-015 The FSM SHALL have exactly four states, IDLE, SPIN, EVAL and PAY; credit is held internally in BCD only.
REQ-016 In IDLE with i_spin_start=1 and credit >= BET, the block SHALL, on that edge, subtract BET using BCD borrow, go to SPIN and assert o_start_ok for the following cycle.
REQ-017 In IDLE with i_spin_start=1 and credit < BET, the block SHALL leave credit unchanged, stay in IDLE and assert o_start_deny for the following cycle.
REQ-018 In IDLE, i_reels_valid SHALL be ignored.
REQ-019 In SPIN, i_spin_start SHALL be ignored; on i_reels_valid=1 the block SHALL latch i_reel0..2 and go to EVAL.
REQ-020 EVAL SHALL last exactly one cycle; on its edge the block SHALL load o_payout and o_win, assert o_result_valid for one cycle, and go to PAY if payout > 0, else to IDLE.
REQ-021 The payout table SHALL be: all three reels equal to 7 gives 50; all three equal to any other digit gives 10; exactly two reels equal gives 2; otherwise 0.
REQ-022 If any latched reel digit is greater than 9, the payout SHALL be 0.
REQ-023 In PAY, each cycle SHALL increment credit by 1 in BCD (carry 009->010, 099->100) and decrement the remaining payout by 1; the block SHALL go to IDLE on the edge where the remaining payout reaches 0.
REQ-024 Credit saturation: if credit is 999 in PAY, credit SHALL stay at 999, the remaining payout SHALL be discarded, and the block SHALL go to IDLE next edge.
REQ-025 The PAY duration SHALL therefore be min(payout, 999 - credit) cycles, plus 1 cycle if saturation occurs.
REQ-026 o_payout and o_win SHALL hold their values until the next EVAL or reset.
REQ-027 o_start_ok, o_start_deny and o_result_valid SHALL never be high for more than one consecutive cycle, and at most one of them SHALL be high in any cycle.

Reset
REQ-028 When i_reset=1 at a clock edge, the block SHALL enter IDLE, load credit with START_CREDIT converted to BCD, and clear o_payout, o_win, o_busy, all pulse outputs and the latched reels.
REQ-029 Reset SHALL take priority over every other input in the same cycle, including a reset asserted in the middle of SPIN or PAY, and any remaining payout SHALL be lost.

Verification
REQ-030 Reset (defaults), then a 1-cycle i_spin_start -> o_start_ok=1 for one cycle, o_credit_bcd 0x010 -> 0x009, o_busy=1.
REQ-031 From SPIN, i_reels_valid with reels 7,7,7 -> o_result_valid pulse, o_payout=50, o_win=1, credit counts 0x009 -> 0x059 over 50 cycles, then o_busy=0.
REQ-032 Reels 3,5,3 -> payout 2 and credit +2; a separate spin with reels 1,2,3 -> payout 0, o_win=0, IDLE one cycle after EVAL with no PAY cycles.
REQ-033 Credit 0x000 and i_spin_start -> o_start_deny pulse, credit unchanged, i_reels_valid then ignored.
REQ-034 Credit 0x990, spin then 7,7,7 -> credit stops at 0x999 and the FSM returns to IDLE.
REQ-035 i_reset asserted mid-PAY -> next cycle credit=0x010, IDLE, o_payout=0; a reel value of 0xA,0xA,0xA -> payout 0.
